servo_slew_ctrl: RTL
====================

// Module: servo_slew_ctrl
// PURPOSE
//  Slew-rate-limited position stage between the servo sequencing FSM (upstream) and the 20 ms PWM generator (downstream).
//  Accepts a target pulse width over a valid/ready handshake and clamps it to the safe range.
//  Moves the PWM duty toward the target by at most STEP counts per PWM frame. Duty changes only at frame boundaries.
//  Holds at the target for HOLD_FRAMES frames, then releases (duty=0, servo unpowered), so no sudden jumps stress the servo.
// PARAMETERS
//  W            19      width of pulse-width/duty values (clk cycles, 25 MHz -> 40 ns/count)
//  MIN_PW       25000   minimum legal pulse width (1.0 ms)
//  MAX_PW       50000   maximum legal pulse width (2.0 ms)
//  CENTER_PW    37500   assumed servo position after reset (1.5 ms)
//  STEP         250     max duty change per frame (must be >= 1)
//  HOLD_FRAMES  100     frames held at target before release (100 x 20 ms = 2 s)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  frame_tick  in   1   1-cycle pulse from PWM stage when its frame counter wraps to 0
//  cmd_valid   in   1   target command valid
//  cmd_pw      in   W   requested target pulse width (clk counts)
//  cmd_ready   out  1   block can accept a command this cycle
//  duty        out  W   pulse width for PWM stage; 0 = no pulse
//  busy        out  1   1 in RAMP or HOLD
//  at_target   out  1   1-cycle pulse when duty first equals target
//  clamped     out  1   sticky: last accepted cmd_pw was outside [MIN_PW,MAX_PW]
// BEHAVIOUR
//  Reset (any cycle, mid-ramp included), effective next edge:
//   - Outputs: state=IDLE, duty=0, cur=CENTER_PW, tgt=CENTER_PW, hold_cnt=0, at_target=0, clamped=0.
//  Handshake:
//   - Accept on cmd_valid & cmd_ready at a rising edge.
//   - cmd_ready = (state==IDLE || state==HOLD); it is 0 in RAMP and during rst.
//   - On accept: tgt <= clamp(cmd_pw, MIN_PW, MAX_PW); clamped <= (cmd_pw<MIN_PW || cmd_pw>MAX_PW); state <= RAMP.
//   - cmd_pw is sampled only at accept and need not stay stable afterwards.
//  IDLE:
//   - duty=0, busy=0.
//   - cur keeps the last position, so the next move starts from there.
//  RAMP (busy=1), on each frame_tick:
//   - cur moves toward tgt by min(STEP,|tgt-cur|); duty <= new cur (registered, same edge).
//   - If the new cur == tgt: at_target=1 for that cycle, hold_cnt <= 0, state <= HOLD.
//   - If tgt == cur at entry: first tick sets duty=cur, pulses at_target and enters HOLD (no zero-length ramp).
//  HOLD (busy=1):
//   - duty stays at tgt; hold_cnt increments on each frame_tick.
//   - On the tick where hold_cnt == HOLD_FRAMES-1: duty <= 0, state <= IDLE. Release is frame-aligned, so no truncated pulse.
//   - A new accepted command returns to RAMP from the current cur; duty is unchanged until the next tick.
//  Timing:
//   - duty is only ever written on frame_tick edges, except reset -> 0.
//   - Latency from accept to first duty change: the next frame_tick, 1..FRAME cycles.
//  Simultaneous events:
//   - Accept and frame_tick in the same cycle: accept wins and the tick is not used as a step (IDLE and HOLD alike).
//   - In HOLD this means duty is kept and hold_cnt is not incremented.
//  Arithmetic:
//   - Difference computed in W+1-bit signed; the step never overshoots tgt.
//   - cur always stays within [MIN_PW,MAX_PW] once a command is accepted.
// TESTING
//  1. rst for 2 cycles, then idle -> duty=0, cmd_ready=1, busy=0, cur=37500.
//  2. cmd 31000, ticks every 500000 cycles -> duty 37250, 37000, ... 31000 after 26 ticks.
//     Check at_target pulse on tick 26, then duty=0 exactly 100 ticks later.
//  3. cmd 60000 -> tgt=50000 and clamped=1; ramp +250/tick; cmd_ready=0 throughout RAMP.
//  4. In HOLD at 44000, cmd 43900 on the same cycle as frame_tick.
//     -> hold_cnt not incremented; next tick duty=43900, at_target pulses, HOLD restarts.
//  5. rst asserted mid-ramp at duty=40000 -> duty=0 next cycle.
//     Next cmd 38000 ramps from 37500: first tick duty=37750.
//  6. From IDLE, cmd equal to cur (31000) -> first tick duty=31000 and at_target=1; 100 ticks later duty=0.

Source files
------------

// File: rtl/servo_slew_ctrl_if.sv
// servo_slew_ctrl_if: command handshake, frame tick and duty/status bundle for the servo slew stage
interface servo_slew_ctrl_if #(parameter int W = 19);
  logic         frame_tick;
  logic         cmd_valid;
  logic [W-1:0] cmd_pw;
  logic         cmd_ready;
  logic [W-1:0] duty;
  logic         busy;
  logic         at_target;
  logic         clamped;
  modport master (output frame_tick, cmd_valid, cmd_pw, input cmd_ready, duty, busy, at_target, clamped);
  modport slave (input frame_tick, cmd_valid, cmd_pw, output cmd_ready, duty, busy, at_target, clamped);
endinterface

// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: frame-aligned slew-limited servo position with clamp, hold and release
module servo_slew_ctrl #(
  parameter int W           = 19,
  parameter int MIN_PW      = 25000,
  parameter int MAX_PW      = 50000,
  parameter int CENTER_PW   = 37500,
  parameter int STEP        = 250,
  parameter int HOLD_FRAMES = 100
) (
  input logic clk,
  input logic rst,
  servo_slew_ctrl_if.slave bus
);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [W-1:0] MIN_V = W'(MIN_PW);
  localparam logic [W-1:0] MAX_V = W'(MAX_PW);
  localparam logic [W-1:0] CEN_V = W'(CENTER_PW);
  localparam logic [W-1:0] STEP_V = W'(STEP);
  localparam logic signed [W:0] STEP_S = (W+1)'(STEP);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
  state_t state, state_n;
  logic [W-1:0] cur, tgt, nxt_cur, duty;
  logic [HW-1:0] hold_cnt;
  logic signed [W:0] diff;
  logic accept, at_target, clamped;
  assign diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
  assign nxt_cur = diff > STEP_S ? cur + STEP_V : diff < -STEP_S ? cur - STEP_V : tgt;
  assign bus.cmd_ready = !rst && state != RAMP;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign bus.duty = duty;
  assign bus.busy = state != IDLE;
  assign bus.at_target = at_target;
  assign bus.clamped = clamped;
  // next state: an accept always wins over a coincident frame tick
  always_comb begin
    state_n = accept ? RAMP
            : !bus.frame_tick ? state
            : (state == RAMP && nxt_cur == tgt) ? HOLD
            : (state == HOLD && hold_cnt == HOLD_LAST) ? IDLE
            : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // datapath: latch clamped target on accept, otherwise step or count on frame ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= '0;
      cur <= CEN_V;
      tgt <= CEN_V;
      hold_cnt <= '0;
      at_target <= 1'b0;
      clamped <= 1'b0;
    end else begin
      at_target <= 1'b0;
      if (accept) begin
        tgt <= bus.cmd_pw < MIN_V ? MIN_V : bus.cmd_pw > MAX_V ? MAX_V : bus.cmd_pw;
        clamped <= bus.cmd_pw < MIN_V || bus.cmd_pw > MAX_V;
      end else if (bus.frame_tick && state == RAMP) begin
        cur <= nxt_cur;
        duty <= nxt_cur;
        if (nxt_cur == tgt) begin
          at_target <= 1'b1;
          hold_cnt <= '0;
        end
      end else if (bus.frame_tick && state == HOLD) begin
        duty <= hold_cnt == HOLD_LAST ? '0 : duty;
        hold_cnt <= hold_cnt == HOLD_LAST ? '0 : hold_cnt + 1'b1;
      end
    end
  end
endmodule
